// File: rtl/program_sequencer.sv
// Fetch/issue sequencer: walks ROM program, issues one datapath strobe per word.
// Optional SEQ_SINGLE_STEP_EN adds a `step` gate on instruction issue.
module program_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      prog_sel,
    output logic [1:0]      prog,
    output logic [PC_W-1:0] address,
    input  logic [7:0]      instruction,
    input  logic            dp_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [3:0]      op,
    output logic [1:0]      r1,
    output logic [1:0]      r2,
    output logic            alu_go,
    output logic            push_go,
    output logic            lda_go,
    output logic            ldb_go,
    output logic            out_go,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      instr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] pc;
    logic            is_alu;
    logic            is_push;
    logic            is_lda;
    logic            is_ldb;
    logic            is_out;
    logic            illegal;
    logic            go;
    logic            fire;
    logic            last_pc;
    logic            accept;

    always_comb begin
        is_alu  = 1'b0;
        is_push = 1'b0;
        is_lda  = 1'b0;
        is_ldb  = 1'b0;
        is_out  = 1'b0;
        illegal = 1'b0;
        unique case (1'b1)
            (op == 4'h8):       is_push = 1'b1;
            (op == 4'h9):       is_lda  = 1'b1;
            (op == 4'hA):       is_ldb  = 1'b1;
            (op == 4'hB):       is_out  = 1'b1;
            (op[3:1] == 3'b111): illegal = 1'b1;
            default:            is_alu  = 1'b1;
        endcase
    end

`ifdef SEQ_SINGLE_STEP_EN
    assign go = dp_ready & step;
`else
    assign go = dp_ready;
`endif

    // Strobes are state-qualified but follow dp_ready combinationally.
    assign fire    = (state == S_EXEC) & go & ~illegal;
    assign alu_go  = fire & is_alu;
    assign push_go = fire & is_push;
    assign lda_go  = fire & is_lda;
    assign ldb_go  = fire & is_ldb;
    assign out_go  = fire & is_out;

    assign last_pc = &pc;
    assign accept  = start & ((state == S_IDLE) | (state == S_HALT));
    assign address = pc;
    assign busy    = (state == S_FETCH) | (state == S_EXEC);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: state_nx = S_EXEC;
            S_EXEC: begin
                if (illegal)
                    state_nx = S_HALT;
                else if (fire)
                    state_nx = (is_out | last_pc) ? S_HALT : S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            prog      <= 2'b00;
            op        <= 4'h0;
            r1        <= 2'b00;
            r2        <= 2'b00;
            done      <= 1'b0;
            err       <= 1'b0;
            instr_cnt <= 8'h00;
        end else begin
            if (accept) begin
                prog      <= prog_sel;
                pc        <= '0;
                done      <= 1'b0;
                err       <= 1'b0;
                instr_cnt <= 8'h00;
            end
            if (state == S_FETCH) begin
                op <= instruction[7:4];
                r1 <= instruction[3:2];
                r2 <= instruction[1:0];
            end
            if (state == S_EXEC) begin
                if (illegal) begin
                    err <= 1'b1;
                end else if (fire) begin
                    if (instr_cnt != 8'hFF)
                        instr_cnt <= instr_cnt + 8'd1;
                    // Top address ends the run rather than wrapping.
                    if (is_out)
                        done <= 1'b1;
                    else if (last_pc)
                        err <= 1'b1;
                    else
                        pc <= pc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a behavioural ROM.
// Define SEQ_SINGLE_STEP_EN to also exercise the step gate.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] prog_sel;
    logic [1:0] prog;
    logic [7:0] address;
    logic [7:0] instruction;
    logic       dp_ready;
    logic       step;
    logic [3:0] op;
    logic [1:0] r1;
    logic [1:0] r2;
    logic       alu_go, push_go, lda_go, ldb_go, out_go;
    logic       busy, done, err;
    logic [7:0] instr_cnt;

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int busy_cyc;
    int multi;
    int ncyc;
    int         lg_code[$];
    int         lg_cyc[$];
    logic [7:0] lg_addr[$];
    logic [3:0] lg_op[$];
    logic [1:0] lg_r1[$];
    logic [1:0] lg_r2[$];

    always #5 clk = ~clk;

    program_sequencer #(.PC_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .prog_sel(prog_sel),
        .prog(prog),
        .address(address),
        .instruction(instruction),
        .dp_ready(dp_ready),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .op(op),
        .r1(r1),
        .r2(r2),
        .alu_go(alu_go),
        .push_go(push_go),
        .lda_go(lda_go),
        .ldb_go(ldb_go),
        .out_go(out_go),
        .busy(busy),
        .done(done),
        .err(err),
        .instr_cnt(instr_cnt)
    );

    // mode 1: illegal word at address 3; mode 2: push everywhere
    function automatic logic [7:0] rom(input int m, input logic [1:0] p,
                                       input logic [7:0] a);
        logic [7:0] w;
        w = 8'hB0;
        if (m == 2) return 8'h80;
        if (m == 1 && a == 8'd3) return 8'hE0;
        case (p)
            2'b00: case (a)
                8'd0: w = 8'h90;
                8'd1: w = 8'hA0;
                8'd2: w = 8'h75;
                default: w = 8'hB0;
            endcase
            2'b01: case (a)
                8'd0: w = 8'h90;
                8'd1: w = 8'hA0;
                8'd2: w = 8'h01;
                8'd3: w = 8'h80;
                8'd4: w = 8'h50;
                8'd5: w = 8'h80;
                default: w = 8'hB0;
            endcase
            2'b11: case (a)
                8'd0:  w = 8'h90;
                8'd1:  w = 8'hA0;
                8'd2:  w = 8'h01;
                8'd3:  w = 8'h12;
                8'd4:  w = 8'h23;
                8'd5:  w = 8'h34;
                8'd6:  w = 8'h45;
                8'd7:  w = 8'h56;
                8'd8:  w = 8'h67;
                8'd9:  w = 8'hC1;
                8'd10: w = 8'hD2;
                8'd11: w = 8'h80;
                default: w = 8'hB0;
            endcase
            default: w = 8'hB0;
        endcase
        return w;
    endfunction

    always_comb instruction = rom(mode, prog, address);

    // Start a run and log every strobe; cycle 0 is the FETCH of address 0.
    task automatic run(input logic [1:0] sel, input int st_from,
                       input int st_n, input int restart_at,
                       input int step_per, input int budget);
        int n;
        lg_code.delete(); lg_cyc.delete(); lg_addr.delete();
        lg_op.delete(); lg_r1.delete(); lg_r2.delete();
        busy_cyc = 0;
        multi = 0;
        ncyc = -1;
        @(posedge clk); #1;
        start = 1'b1; prog_sel = sel; dp_ready = 1'b1; step = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; prog_sel = ~sel;
        for (int c = 0; c < budget; c++) begin
            dp_ready = !(c >= st_from && c < st_from + st_n);
            step = (step_per == 0) ? 1'b1 : (c % step_per == step_per - 1);
            start = (c == restart_at);
            #1;
            if (busy) busy_cyc++;
            n = int'(alu_go) + int'(push_go) + int'(lda_go)
              + int'(ldb_go) + int'(out_go);
            if (n > 1) multi++;
            if (n == 1) begin
                lg_code.push_back(alu_go ? 0 : push_go ? 1 : lda_go ? 2 :
                                  ldb_go ? 3 : 4);
                lg_cyc.push_back(c);
                lg_addr.push_back(address);
                lg_op.push_back(op);
                lg_r1.push_back(r1);
                lg_r2.push_back(r2);
            end
            if (!busy) begin
                ncyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; dp_ready = 1'b1; step = 1'b1;
        checks++;
        if (ncyc < 0) begin
            errors++;
            $display("FAIL run_timeout: busy=%0b after %0d cycles, required 0",
                     busy, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; prog_sel = 2'b00;
        dp_ready = 1'b1; step = 1'b1;
        #3;
        checks++;
        if ({prog, address, op, r1, r2, alu_go, push_go, lda_go, ldb_go,
             out_go, busy, done, err, instr_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%0h op=%0h busy=%0b cnt=%0d, required all 0",
                     address, op, busy, instr_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_program();
        int exp_code[7] = '{2, 3, 0, 1, 0, 1, 4};
        mode = 0;
        run(2'b01, 100, 0, -1, 0, 100);
        checks++;
        if (lg_code.size() != 7) begin
            errors++;
            $display("FAIL prog1_count: got %0d strobes, required 7", lg_code.size());
        end
        for (int i = 0; i < 7 && i < lg_code.size(); i++) begin
            checks++;
            if (lg_code[i] !== exp_code[i] || lg_cyc[i] !== 2 * i + 1 ||
                lg_addr[i] !== 8'(i)) begin
                errors++;
                $display("FAIL prog1_strobe%0d: code=%0d cyc=%0d addr=%0d, required %0d %0d %0d",
                         i, lg_code[i], lg_cyc[i], lg_addr[i], exp_code[i], 2 * i + 1, i);
            end
        end
        if (lg_code.size() >= 5) begin
            checks++;
            if ({lg_op[2], lg_r1[2], lg_r2[2]} !== {4'h0, 2'd0, 2'd1} ||
                lg_op[4] !== 4'h5) begin
                errors++;
                $display("FAIL prog1_alu_fields: op=%0h r1=%0d r2=%0d op4=%0h, required 0 0 1 5",
                         lg_op[2], lg_r1[2], lg_r2[2], lg_op[4]);
            end
        end
        checks++;
        if ({done, err, instr_cnt, prog, address} !== {1'b1, 1'b0, 8'd7, 2'b01, 8'd6}) begin
            errors++;
            $display("FAIL prog1_final: done=%0b err=%0b cnt=%0d prog=%0d addr=%0d, required 1 0 7 1 6",
                     done, err, instr_cnt, prog, address);
        end
        checks++;
        if (busy_cyc !== 14 || multi !== 0) begin
            errors++;
            $display("FAIL prog1_busy: busy=%0d multi=%0d, required 14 0", busy_cyc, multi);
        end
    endtask

    task automatic test_stall();
        mode = 0;
        run(2'b01, 5, 3, -1, 0, 100);
        checks++;
        if (lg_code.size() != 7) begin
            errors++;
            $display("FAIL stall_count: got %0d strobes, required 7", lg_code.size());
        end
        if (lg_code.size() == 7) begin
            checks++;
            if (lg_code[2] !== 0 || lg_cyc[2] !== 8 || lg_addr[2] !== 8'd2) begin
                errors++;
                $display("FAIL stall_alu: code=%0d cyc=%0d addr=%0d, required 0 8 2",
                         lg_code[2], lg_cyc[2], lg_addr[2]);
            end
            checks++;
            if (lg_cyc[1] !== 3 || lg_cyc[3] !== 10 || lg_cyc[6] !== 16) begin
                errors++;
                $display("FAIL stall_cadence: cyc1=%0d cyc3=%0d cyc6=%0d, required 3 10 16",
                         lg_cyc[1], lg_cyc[3], lg_cyc[6]);
            end
        end
        checks++;
        if (busy_cyc !== 17 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_busy: busy=%0d done=%0b, required 17 1", busy_cyc, done);
        end
    endtask

    task automatic test_illegal();
        mode = 1;
        run(2'b01, 7, 5, -1, 0, 100);
        checks++;
        if (lg_code.size() != 3) begin
            errors++;
            $display("FAIL illegal_count: got %0d strobes, required 3", lg_code.size());
        end
        checks++;
        if ({err, done, instr_cnt, op, address} !== {1'b1, 1'b0, 8'd3, 4'hE, 8'd3}) begin
            errors++;
            $display("FAIL illegal_final: err=%0b done=%0b cnt=%0d op=%0h addr=%0d, required 1 0 3 e 3",
                     err, done, instr_cnt, op, address);
        end
        checks++;
        if (busy_cyc !== 8) begin
            errors++;
            $display("FAIL illegal_busy: got %0d, required 8", busy_cyc);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (op !== 4'hE || push_go !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_hold: op=%0h push=%0b busy=%0b, required e 0 0",
                     op, push_go, busy);
        end
        mode = 0;
    endtask

    task automatic test_overflow();
        int bad;
        mode = 2;
        run(2'b10, 1000, 0, -1, 0, 700);
        checks++;
        if (lg_code.size() != 256) begin
            errors++;
            $display("FAIL ovf_count: got %0d strobes, required 256", lg_code.size());
        end
        bad = 0;
        for (int i = 0; i < lg_code.size(); i++)
            if (lg_code[i] != 1 || lg_addr[i] != 8'(i) || lg_cyc[i] != 2 * i + 1) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ovf_sequence: %0d bad strobes, required 0", bad);
        end
        checks++;
        if ({err, done, address, instr_cnt} !== {1'b1, 1'b0, 8'd255, 8'd255}) begin
            errors++;
            $display("FAIL ovf_final: err=%0b done=%0b addr=%0d cnt=%0d, required 1 0 255 255",
                     err, done, address, instr_cnt);
        end
        checks++;
        if (busy_cyc !== 512) begin
            errors++;
            $display("FAIL ovf_busy: got %0d, required 512", busy_cyc);
        end
        mode = 0;
    endtask

    task automatic test_midrun_reset();
        mode = 0;
        @(posedge clk); #1;
        start = 1'b1; prog_sel = 2'b01; dp_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (address !== 8'd4 || alu_go !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: addr=%0d alu=%0b, required 4 1", address, alu_go);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({prog, address, op, r1, r2, alu_go, push_go, lda_go, ldb_go,
             out_go, busy, done, err, instr_cnt} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: addr=%0h op=%0h alu=%0b busy=%0b cnt=%0d, required all 0",
                     address, op, alu_go, busy, instr_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        run(2'b11, 100, 0, 3, 0, 100);
        checks++;
        if (lg_code.size() != 13 || multi !== 0) begin
            errors++;
            $display("FAIL p3_count: got %0d strobes multi=%0d, required 13 0",
                     lg_code.size(), multi);
        end
        if (lg_code.size() == 13) begin
            checks++;
            if (lg_code[12] !== 4 || lg_addr[12] !== 8'd12 || lg_code[11] !== 1 ||
                lg_code[9] !== 0 || lg_op[10] !== 4'hD) begin
                errors++;
                $display("FAIL p3_tail: code12=%0d addr12=%0d code11=%0d code9=%0d op10=%0h, required 4 12 1 0 d",
                         lg_code[12], lg_addr[12], lg_code[11], lg_code[9], lg_op[10]);
            end
        end
        checks++;
        if ({done, err, instr_cnt, prog} !== {1'b1, 1'b0, 8'd13, 2'b11} || busy_cyc !== 26) begin
            errors++;
            $display("FAIL p3_final: done=%0b err=%0b cnt=%0d prog=%0d busy=%0d, required 1 0 13 3 26",
                     done, err, instr_cnt, prog, busy_cyc);
        end
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_step();
        int exp_code[4] = '{2, 3, 0, 4};
        mode = 0;
        run(2'b00, 1000, 0, 2, 5, 200);
        checks++;
        if (lg_code.size() != 4) begin
            errors++;
            $display("FAIL step_count: got %0d strobes, required 4", lg_code.size());
        end
        for (int i = 0; i < 4 && i < lg_code.size(); i++) begin
            checks++;
            if (lg_code[i] !== exp_code[i] || lg_cyc[i] !== 5 * i + 4) begin
                errors++;
                $display("FAIL step_strobe%0d: code=%0d cyc=%0d, required %0d %0d",
                         i, lg_code[i], lg_cyc[i], exp_code[i], 5 * i + 4);
            end
        end
        checks++;
        if (busy_cyc !== 20 || done !== 1'b1 || instr_cnt !== 8'd4) begin
            errors++;
            $display("FAIL step_final: busy=%0d done=%0b cnt=%0d, required 20 1 4",
                     busy_cyc, done, instr_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_program();
        test_stall();
        test_illegal();
        test_overflow();
        test_midrun_reset();
`ifdef SEQ_SINGLE_STEP_EN
        test_step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
